// File: rtl/vector_cpu_pkg.sv
// Shared types and constants for the vector CPU write-back path.
// Optional feature macro used downstream: WB_SAT_EN (pixel saturation in pix_pack).
package vector_cpu_pkg;

  localparam int VEC_DATA_W = 32;
  localparam int PIX_W      = 8;
  localparam int LANES      = 4;
  localparam int WB_AW      = 16;

  typedef logic [LANES-1:0][VEC_DATA_W-1:0] lanes_t;

  // One EX -> WB request; lanes[0] carries res1.
  typedef struct packed {
    logic             wr_pxl;
    logic             wr_pos;
    logic             wr_mul;
    logic             wr_wom;
    logic             wom_auto;
    logic [WB_AW-1:0] addr;
    lanes_t           lanes;
  } wb_req_t;

endpackage

// File: rtl/vector_cpu_wb_pix_pack.sv
// Reduces four signed lanes to 8-bit pixels packed as {p4,p3,p2,p1}.
// WB_SAT_EN defined: clamp each lane to [0,255]; otherwise keep res[7:0].
module pix_pack
  import vector_cpu_pkg::*;
#(
  parameter int DATA_W = VEC_DATA_W
) (
  input  logic [LANES-1:0][DATA_W-1:0] lanes,
  output logic [LANES*PIX_W-1:0]       packed_px
);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [PIX_W-1:0] px;
`ifdef WB_SAT_EN
      // Sign bit first: any negative lane is 0, any set magnitude bit above 7 saturates.
      assign px = lanes[gi][DATA_W-1]                ? '0 :
                  (|lanes[gi][DATA_W-2:PIX_W])       ? '1 :
                  lanes[gi][PIX_W-1:0];
`else
      logic unused_hi;
      assign unused_hi = ^lanes[gi][DATA_W-1:PIX_W];
      assign px        = lanes[gi][PIX_W-1:0];
`endif
      assign packed_px[gi*PIX_W +: PIX_W] = px;
    end
  endgenerate

endmodule

// File: rtl/vector_cpu_wb.sv
// Vector CPU write-back stage: regfile write ports, WOM valid/ready output, auto address counter.
// Build option WB_SAT_EN selects saturating pixel packing (see pix_pack).
module vector_cpu_wb
  import vector_cpu_pkg::*;
#(
  parameter int DATA_W    = VEC_DATA_W,
  parameter int WOM_AW    = WB_AW,
  parameter int WOM_DEPTH = 65536
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_wr_pxl,
  input  logic              ex_wr_pos,
  input  logic              ex_wr_mul,
  input  logic              ex_wr_wom,
  input  logic              ex_wom_auto,
  input  logic [WOM_AW-1:0] ex_wom_addr,
  input  logic [DATA_W-1:0] ex_res1,
  input  logic [DATA_W-1:0] ex_res2,
  input  logic [DATA_W-1:0] ex_res3,
  input  logic [DATA_W-1:0] ex_res4,
  output logic              we_pxl,
  output logic              wr_pos_pxl,
  output logic [DATA_W-1:0] wdp1,
  output logic [DATA_W-1:0] wdp2,
  output logic [DATA_W-1:0] wdp3,
  output logic [DATA_W-1:0] wdp4,
  output logic              we_mul,
  output logic              wr_mul_pos,
  output logic [DATA_W-1:0] wdm1,
  output logic [DATA_W-1:0] wdm2,
  output logic [DATA_W-1:0] wdm3,
  output logic [DATA_W-1:0] wdm4,
  output logic              wom_we,
  input  logic              wom_ready,
  output logic [WOM_AW-1:0] wom_waddr,
  output logic [31:0]       wom_wdata,
  output logic              frame_done
);

  localparam logic [WOM_AW-1:0] CNT_LAST = WOM_AW'(WOM_DEPTH - 1);

  wb_req_t                  req;
  logic [LANES*PIX_W-1:0]   packed_px;
  logic                     xfer;
  logic                     wom_accept;
  logic [WOM_AW-1:0]        cnt_adv;

  logic                     we_pxl_reg,      we_pxl_next;
  logic                     wr_pos_pxl_reg,  wr_pos_pxl_next;
  lanes_t                   wdp_reg,         wdp_next;
  logic                     we_mul_reg,      we_mul_next;
  logic                     wr_mul_pos_reg,  wr_mul_pos_next;
  lanes_t                   wdm_reg,         wdm_next;
  logic                     wom_pend_reg,    wom_pend_next;
  logic                     wom_auto_reg,    wom_auto_next;
  logic [WOM_AW-1:0]        wom_waddr_reg,   wom_waddr_next;
  logic [31:0]              wom_wdata_reg,   wom_wdata_next;
  logic [WOM_AW-1:0]        cnt_reg,         cnt_next;
  logic                     frame_done_reg,  frame_done_next;

  always_comb begin
    req          = '0;
    req.wr_pxl   = ex_wr_pxl;
    req.wr_pos   = ex_wr_pos;
    req.wr_mul   = ex_wr_mul;
    req.wr_wom   = ex_wr_wom;
    req.wom_auto = ex_wom_auto;
    req.addr     = WB_AW'(ex_wom_addr);
    req.lanes    = {ex_res4, ex_res3, ex_res2, ex_res1};
  end

  pix_pack #(.DATA_W(DATA_W)) u_pix_pack (
    .lanes     (req.lanes),
    .packed_px (packed_px)
  );

  assign ex_ready   = !wom_pend_reg || wom_ready;
  assign xfer       = ex_valid && ex_ready;
  assign wom_accept = wom_pend_reg && wom_ready;
  assign cnt_adv    = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;

  always_comb begin
    we_pxl_next     = 1'b0;
    wr_pos_pxl_next = wr_pos_pxl_reg;
    wdp_next        = wdp_reg;
    we_mul_next     = 1'b0;
    wr_mul_pos_next = wr_mul_pos_reg;
    wdm_next        = wdm_reg;
    wom_pend_next   = wom_pend_reg;
    wom_auto_next   = wom_auto_reg;
    wom_waddr_next  = wom_waddr_reg;
    wom_wdata_next  = wom_wdata_reg;
    cnt_next        = cnt_reg;
    frame_done_next = 1'b0;

    if (we_mul_reg)
      wr_mul_pos_next = ~wr_mul_pos_reg;

    if (wom_accept) begin
      wom_pend_next = 1'b0;
      if (wom_auto_reg) begin
        cnt_next        = cnt_adv;
        frame_done_next = (cnt_reg == CNT_LAST);
      end
    end

    if (xfer) begin
      if (req.wr_pxl) begin
        we_pxl_next     = 1'b1;
        wr_pos_pxl_next = req.wr_pos;
        wdp_next        = req.lanes;
      end
      if (req.wr_mul) begin
        we_mul_next = 1'b1;
        wdm_next    = req.lanes;
      end
      // A new auto word takes the address after this cycle's accept, enabling 1 word/cycle.
      if (req.wr_wom) begin
        wom_pend_next  = 1'b1;
        wom_auto_next  = req.wom_auto;
        wom_waddr_next = req.wom_auto ? cnt_next : WOM_AW'(req.addr);
        wom_wdata_next = packed_px;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_pxl_reg     <= 1'b0;
      wr_pos_pxl_reg <= 1'b0;
      wdp_reg        <= '0;
      we_mul_reg     <= 1'b0;
      wr_mul_pos_reg <= 1'b0;
      wdm_reg        <= '0;
      wom_pend_reg   <= 1'b0;
      wom_auto_reg   <= 1'b0;
      wom_waddr_reg  <= '0;
      wom_wdata_reg  <= '0;
      cnt_reg        <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      we_pxl_reg     <= we_pxl_next;
      wr_pos_pxl_reg <= wr_pos_pxl_next;
      wdp_reg        <= wdp_next;
      we_mul_reg     <= we_mul_next;
      wr_mul_pos_reg <= wr_mul_pos_next;
      wdm_reg        <= wdm_next;
      wom_pend_reg   <= wom_pend_next;
      wom_auto_reg   <= wom_auto_next;
      wom_waddr_reg  <= wom_waddr_next;
      wom_wdata_reg  <= wom_wdata_next;
      cnt_reg        <= cnt_next;
      frame_done_reg <= frame_done_next;
    end
  end

  assign we_pxl     = we_pxl_reg;
  assign wr_pos_pxl = wr_pos_pxl_reg;
  assign wdp1       = wdp_reg[0];
  assign wdp2       = wdp_reg[1];
  assign wdp3       = wdp_reg[2];
  assign wdp4       = wdp_reg[3];
  assign we_mul     = we_mul_reg;
  assign wr_mul_pos = wr_mul_pos_reg;
  assign wdm1       = wdm_reg[0];
  assign wdm2       = wdm_reg[1];
  assign wdm3       = wdm_reg[2];
  assign wdm4       = wdm_reg[3];
  assign wom_we     = wom_pend_reg;
  assign wom_waddr  = wom_waddr_reg;
  assign wom_wdata  = wom_wdata_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_vector_cpu_wb.sv
// Directed bench for vector_cpu_wb with a 4-word frame; expectations are hand-computed.
module tb_vector_cpu_wb;

  localparam int DW = 32;
  localparam int AW = 16;

`ifdef WB_SAT_EN
  localparam logic [31:0] EXP_W2 = 32'hFF0700FF;
`else
  localparam logic [31:0] EXP_W2 = 32'hFF07FB2C;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          ex_valid, ex_ready;
  logic          ex_wr_pxl, ex_wr_pos, ex_wr_mul, ex_wr_wom, ex_wom_auto;
  logic [AW-1:0] ex_wom_addr;
  logic [DW-1:0] ex_res1, ex_res2, ex_res3, ex_res4;
  logic          we_pxl, wr_pos_pxl, we_mul, wr_mul_pos;
  logic [DW-1:0] wdp1, wdp2, wdp3, wdp4, wdm1, wdm2, wdm3, wdm4;
  logic          wom_we, wom_ready, frame_done;
  logic [AW-1:0] wom_waddr;
  logic [31:0]   wom_wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vector_cpu_wb #(.DATA_W(DW), .WOM_AW(AW), .WOM_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_wr_pxl(ex_wr_pxl), .ex_wr_pos(ex_wr_pos), .ex_wr_mul(ex_wr_mul),
    .ex_wr_wom(ex_wr_wom), .ex_wom_auto(ex_wom_auto), .ex_wom_addr(ex_wom_addr),
    .ex_res1(ex_res1), .ex_res2(ex_res2), .ex_res3(ex_res3), .ex_res4(ex_res4),
    .we_pxl(we_pxl), .wr_pos_pxl(wr_pos_pxl),
    .wdp1(wdp1), .wdp2(wdp2), .wdp3(wdp3), .wdp4(wdp4),
    .we_mul(we_mul), .wr_mul_pos(wr_mul_pos),
    .wdm1(wdm1), .wdm2(wdm2), .wdm3(wdm3), .wdm4(wdm4),
    .wom_we(wom_we), .wom_ready(wom_ready), .wom_waddr(wom_waddr),
    .wom_wdata(wom_wdata), .frame_done(frame_done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic idle();
    ex_valid    = 1'b0;
    ex_wr_pxl   = 1'b0;
    ex_wr_pos   = 1'b0;
    ex_wr_mul   = 1'b0;
    ex_wr_wom   = 1'b0;
    ex_wom_auto = 1'b0;
    ex_wom_addr = '0;
  endtask

  task automatic set_res(input int r1, input int r2, input int r3, input int r4);
    ex_res1 = r1;
    ex_res2 = r2;
    ex_res3 = r3;
    ex_res4 = r4;
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    wom_ready = 1'b1;
    idle();
    set_res(0, 0, 0, 0);
    step();
    check("rst_we_mul", we_mul, 0);
    check("rst_wr_mul_pos", wr_mul_pos, 0);
    check("rst_wom_we", wom_we, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_waddr", wom_waddr, 0);
    check("rst_ex_ready", ex_ready, 1);
    step();
    rst = 1'b1;

    // Two mul writes fill half 0 then half 1
    ex_valid = 1'b1; ex_wr_mul = 1'b1;
    set_res(15, 16, 17, 18);
    step();
    check("mul1_we", we_mul, 1);
    check("mul1_pos", wr_mul_pos, 0);
    check("mul1_wdm1", wdm1, 15);
    check("mul1_wdm4", wdm4, 18);
    set_res(150, 160, 170, 180);
    step();
    check("mul2_we", we_mul, 1);
    check("mul2_pos", wr_mul_pos, 1);
    check("mul2_wdm1", wdm1, 150);
    check("mul2_wdm4", wdm4, 180);
    idle();
    step();
    check("mul_idle_we", we_mul, 0);
    check("mul_idle_hold", wdm2, 160);
    check("mul_idle_pos", wr_mul_pos, 0);

    // Pixel write at position 1
    ex_valid = 1'b1; ex_wr_pxl = 1'b1; ex_wr_pos = 1'b1;
    set_res(1, 2, 3, 4);
    step();
    check("pxl_we", we_pxl, 1);
    check("pxl_pos", wr_pos_pxl, 1);
    check("pxl_wdp1", wdp1, 1);
    check("pxl_wdp3", wdp3, 3);
    check("pxl_no_mul", we_mul, 0);
    idle();
    step();
    check("pxl_idle_we", we_pxl, 0);
    check("pxl_idle_hold", wdp4, 4);

    // Explicitly addressed WOM word with out-of-range lanes
    ex_valid = 1'b1; ex_wr_wom = 1'b1; ex_wom_addr = 16'h0010;
    set_res(300, -5, 7, 255);
    step();
    check("wom2_we", wom_we, 1);
    check("wom2_addr", wom_waddr, 16'h0010);
    check("wom2_data", wom_wdata, EXP_W2);
    idle();
    step();
    check("wom2_done", wom_we, 0);
    check("wom2_no_frame", frame_done, 0);

    // Stall: held EX request must wait while WOM is not ready
    wom_ready = 1'b0;
    ex_valid = 1'b1; ex_wr_wom = 1'b1; ex_wom_addr = 16'h0020;
    set_res(1, 2, 3, 4);
    step();
    check("st_we", wom_we, 1);
    ex_wom_addr = 16'h0030;
    set_res(9, 10, 11, 12);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("st_ready_%0d", i), ex_ready, 0);
      check($sformatf("st_addr_%0d", i), wom_waddr, 16'h0020);
      check($sformatf("st_data_%0d", i), wom_wdata, 32'h04030201);
      step();
    end
    wom_ready = 1'b1;
    #1;
    check("st_ready_rel", ex_ready, 1);
    step();
    check("st_reload_we", wom_we, 1);
    check("st_reload_addr", wom_waddr, 16'h0030);
    check("st_reload_data", wom_wdata, 32'h0C0B0A09);
    idle();
    step();
    check("st_drain", wom_we, 0);

    // Auto addresses across the 4-word frame boundary, back to back
    ex_valid = 1'b1; ex_wr_wom = 1'b1; ex_wom_auto = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_res(k, 0, 0, 0);
      step();
      check($sformatf("auto_addr_%0d", k), wom_waddr, k % 4);
      check($sformatf("auto_data_%0d", k), wom_wdata, k);
      check($sformatf("auto_fd_%0d", k), frame_done, (k == 4) ? 1 : 0);
    end
    idle();
    step();
    check("auto_drain", wom_we, 0);
    check("auto_fd_clear", frame_done, 0);

    // Reset while a word is stalled and the mul half is 1
    wom_ready = 1'b0;
    ex_valid = 1'b1; ex_wr_wom = 1'b1; ex_wom_auto = 1'b1; ex_wr_mul = 1'b1;
    set_res(5, 6, 7, 8);
    step();
    check("rs_we", wom_we, 1);
    check("rs_addr", wom_waddr, 1);
    idle();
    step();
    check("rs_pos_before", wr_mul_pos, 1);
    #2;
    rst = 1'b0;
    #1;
    check("rs_wom_we", wom_we, 0);
    check("rs_pos", wr_mul_pos, 0);
    check("rs_addr0", wom_waddr, 0);
    check("rs_ready", ex_ready, 1);
    step();
    rst = 1'b1;
    wom_ready = 1'b1;
    ex_valid = 1'b1; ex_wr_wom = 1'b1; ex_wom_auto = 1'b1;
    step();
    check("rs_cnt_zero", wom_waddr, 0);
    idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
